// File: rtl/sram_arbiter_pkg.sv
// Shared types and defaults for the single-port SRAM arbiter between
// the instruction-fetch port and the data load/store port.
package sram_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;

  // Which requester owns the read data coming back from memory next cycle
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } owner_e;

endpackage

// File: rtl/sram_arbiter_rdata_hold.sv
// Per-requester read-return register: flags the return cycle and keeps the
// last returned word so the core sees stable data while it is stalled.
module rdata_hold #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cap_i,
  input  logic [DATA_W-1:0] d_i,
  output logic              rvalid_o,
  output logic [DATA_W-1:0] data_o
);

  logic [DATA_W-1:0] hold_q;
  logic [DATA_W-1:0] hold_d;

  assign hold_d = cap_i ? d_i : hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) hold_q <= '0;
    else      hold_q <= hold_d;
  end

  // The return cycle forwards memory data directly; afterwards the held copy is shown.
  assign rvalid_o = cap_i;
  assign data_o   = cap_i ? d_i : hold_q;

endmodule

// File: rtl/sram_arbiter.sv
// Arbitrates one single-port synchronous SRAM between fetch and data ports:
// data has priority, but a fetch refused MAX_WAIT times in a row wins next.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_WAIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_gnt,
  output logic                inst_rvalid,
  output logic [DATA_W-1:0]   inst_rdata,
  input  logic                data_req,
  input  logic [DATA_W/8-1:0] data_wen,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_gnt,
  output logic                data_rvalid,
  output logic [DATA_W-1:0]   data_rdata,
  output logic                mem_en,
  output logic [DATA_W/8-1:0] mem_wen,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                stallreq
);

  localparam int WCNT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WCNT_W-1:0] WAIT_MAX = WCNT_W'(MAX_WAIT);

  owner_e            owner_q, owner_d;
  logic [WCNT_W-1:0] waitCnt_q, waitCnt_d;
  logic              instWin, dataWin;
  logic              instCap, dataCap;

  // Grants are suppressed entirely while reset is held low.
  assign instWin = rst & inst_req & (~data_req | (waitCnt_q == WAIT_MAX));
  assign dataWin = rst & data_req & ~instWin;

  assign inst_gnt = instWin;
  assign data_gnt = dataWin;
  assign stallreq = rst & ((inst_req & ~instWin) | (data_req & ~dataWin));

  always_comb begin
    mem_en    = 1'b0;
    mem_wen   = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (instWin) begin
      mem_en   = 1'b1;
      mem_addr = inst_addr;
    end else if (dataWin) begin
      mem_en    = 1'b1;
      mem_wen   = data_wen;
      mem_addr  = data_addr;
      mem_wdata = data_wdata;
    end
  end

  always_comb begin
    waitCnt_d = '0;
    if (inst_req && !instWin)
      waitCnt_d = (waitCnt_q == WAIT_MAX) ? WAIT_MAX : waitCnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      owner_q   <= OWN_NONE;
      waitCnt_q <= '0;
    end else begin
      owner_q   <= owner_d;
      waitCnt_q <= waitCnt_d;
    end
  end

  // Writes commit in the grant cycle and leave nothing outstanding.
  always_comb begin
    owner_d = OWN_NONE;
    if (instWin)                      owner_d = OWN_INST;
    else if (dataWin && ~|data_wen)   owner_d = OWN_DATA;
  end

  always_comb begin
    instCap = (owner_q == OWN_INST);
    dataCap = (owner_q == OWN_DATA);
  end

  rdata_hold #(.DATA_W(DATA_W)) u_instHold (
    .clk      (clk),
    .rst      (rst),
    .cap_i    (instCap),
    .d_i      (mem_rdata),
    .rvalid_o (inst_rvalid),
    .data_o   (inst_rdata)
  );

  rdata_hold #(.DATA_W(DATA_W)) u_dataHold (
    .clk      (clk),
    .rst      (rst),
    .cap_i    (dataCap),
    .d_i      (mem_rdata),
    .rvalid_o (data_rvalid),
    .data_o   (data_rdata)
  );

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a small synchronous SRAM model whose
// read contents are a fixed, hand-computable function of the address.
module tb_sram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_gnt;
  logic        inst_rvalid;
  logic [31:0] inst_rdata;
  logic        data_req;
  logic [3:0]  data_wen;
  logic [31:0] data_addr;
  logic [31:0] data_wdata;
  logic        data_gnt;
  logic        data_rvalid;
  logic [31:0] data_rdata;
  logic        mem_en;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        stallreq;

  int checkCount = 0;
  int passCount  = 0;

  sram_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(4)) dut (
    .clk(clk), .rst(rst),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr),
    .data_wdata(data_wdata), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_rdata(data_rdata),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stallreq(stallreq)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memModel(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: return 32'h3C1D_8000;
      32'h0000_1000: return 32'h1234_5678;
      default:       return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  always @(posedge clk)
    if (mem_en && mem_wen == 4'b0000) mem_rdata <= memModel(mem_addr);

  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs;
    inst_req = 0; inst_addr = '0;
    data_req = 0; data_wen = '0; data_addr = '0; data_wdata = '0;
  endtask

  task automatic test_reset;
    rst = 0;
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    data_req = 1; data_addr = 32'h1000;
    #2;
    checkCount++;
    if ({inst_gnt, data_gnt, stallreq, mem_en} !== 4'b0000)
      $display("FAIL reset_grants: got %b expected 0000", {inst_gnt, data_gnt, stallreq, mem_en});
    else passCount++;
    checkCount++;
    if ({mem_wen, mem_addr, mem_wdata} !== 68'd0)
      $display("FAIL reset_mem: got wen=%h addr=%h wdata=%h expected 0", mem_wen, mem_addr, mem_wdata);
    else passCount++;
    checkCount++;
    if ({inst_rvalid, data_rvalid, inst_rdata, data_rdata} !== 66'd0)
      $display("FAIL reset_returns: got ir=%b dr=%b id=%h dd=%h expected 0", inst_rvalid, data_rvalid, inst_rdata, data_rdata);
    else passCount++;
    idleInputs();
    nextCycle();
    rst = 1;
  endtask

  task automatic test_inst_read;
    nextCycle();
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    checkCount++;
    if ({inst_gnt, data_gnt, stallreq, mem_en} !== 4'b1001)
      $display("FAIL inst_grant: got %b expected 1001", {inst_gnt, data_gnt, stallreq, mem_en});
    else passCount++;
    checkCount++;
    if (mem_addr !== 32'hBFC0_0000 || mem_wen !== 4'b0000 || mem_wdata !== 32'd0)
      $display("FAIL inst_mem: got addr=%h wen=%b wdata=%h expected bfc00000/0000/0", mem_addr, mem_wen, mem_wdata);
    else passCount++;
    nextCycle();
    inst_req = 0;
    checkCount++;
    if (inst_rvalid !== 1'b1 || inst_rdata !== 32'h3C1D_8000)
      $display("FAIL inst_return: got rvalid=%b data=%h expected 1/3c1d8000", inst_rvalid, inst_rdata);
    else passCount++;
  endtask

  task automatic test_contention;
    logic expData;
    nextCycle();
    for (int i = 0; i < 6; i++) begin
      if (i > 0) nextCycle();
      if (i == 1) begin
        checkCount++;
        if (data_rvalid !== 1'b1 || data_rdata !== 32'h1234_5678)
          $display("FAIL contend_data_return: got rvalid=%b data=%h expected 1/12345678", data_rvalid, data_rdata);
        else passCount++;
      end
      inst_req = 1; inst_addr = 32'h0000_0040;
      data_req = 1; data_wen = 4'b0000; data_addr = 32'h1000;
      #1;
      expData = (i != 4);
      checkCount++;
      if (data_gnt !== expData || inst_gnt !== !expData || stallreq !== 1'b1)
        $display("FAIL contend_cycle%0d: got dg=%b ig=%b stall=%b expected dg=%b ig=%b stall=1",
                 i, data_gnt, inst_gnt, stallreq, expData, !expData);
      else passCount++;
    end
    nextCycle();
    idleInputs();
  endtask

  task automatic test_store;
    nextCycle();
    data_req = 1; data_wen = 4'b0011; data_addr = 32'h2000; data_wdata = 32'hDEAD_BEEF;
    #1;
    checkCount++;
    if ({data_gnt, mem_en, mem_wen, stallreq} !== 7'b1_1_0011_0 || mem_addr !== 32'h2000 || mem_wdata !== 32'hDEAD_BEEF)
      $display("FAIL store_mem: got gnt=%b en=%b wen=%b addr=%h wdata=%h expected 1/1/0011/2000/deadbeef",
               data_gnt, mem_en, mem_wen, mem_addr, mem_wdata);
    else passCount++;
    nextCycle();
    idleInputs();
    checkCount++;
    if (data_rvalid !== 1'b0)
      $display("FAIL store_no_rvalid: got %b expected 0", data_rvalid);
    else passCount++;
  endtask

  task automatic test_hold;
    int pulses = 0;
    nextCycle();
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h1000;
    #1;
    checkCount++;
    if (data_gnt !== 1'b1)
      $display("FAIL hold_data_grant: got %b expected 1", data_gnt);
    else passCount++;
    for (int i = 0; i < 5; i++) begin
      nextCycle();
      if (data_rvalid === 1'b1) pulses++;
      checkCount++;
      if (data_rdata !== 32'h1234_5678)
        $display("FAIL hold_data_cycle%0d: got %h expected 12345678", i, data_rdata);
      else passCount++;
      if (i == 2) begin
        checkCount++;
        if (inst_rvalid !== 1'b1 || inst_rdata !== 32'hA5A5_0104)
          $display("FAIL hold_inst_return: got rvalid=%b data=%h expected 1/a5a50104", inst_rvalid, inst_rdata);
        else passCount++;
      end
      data_req = 0;
      inst_req = 1; inst_addr = 32'h100 + 32'(4 * i);
    end
    nextCycle();
    if (data_rvalid === 1'b1) pulses++;
    idleInputs();
    checkCount++;
    if (pulses !== 1)
      $display("FAIL hold_rvalid_pulses: got %0d expected 1", pulses);
    else passCount++;
  endtask

  task automatic test_reset_mid_read;
    nextCycle();
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    #1;
    checkCount++;
    if (inst_gnt !== 1'b1)
      $display("FAIL midreset_grant: got %b expected 1", inst_gnt);
    else passCount++;
    nextCycle();
    inst_req = 0;
    rst = 0;
    #1;
    checkCount++;
    if (inst_rvalid !== 1'b0 || inst_rdata !== 32'd0)
      $display("FAIL midreset_during: got rvalid=%b data=%h expected 0/0", inst_rvalid, inst_rdata);
    else passCount++;
    nextCycle();
    rst = 1;
    nextCycle();
    checkCount++;
    if (inst_rvalid !== 1'b0 || inst_rdata !== 32'd0)
      $display("FAIL midreset_after: got rvalid=%b data=%h expected 0/0", inst_rvalid, inst_rdata);
    else passCount++;
    inst_req = 1; inst_addr = 32'h40;
    data_req = 1; data_wen = 4'b0000; data_addr = 32'h1000;
    #1;
    checkCount++;
    if (data_gnt !== 1'b1 || inst_gnt !== 1'b0)
      $display("FAIL midreset_priority: got dg=%b ig=%b expected 1/0", data_gnt, inst_gnt);
    else passCount++;
    nextCycle();
    idleInputs();
  endtask

  initial begin
    rst = 0;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_inst_read();
    test_contention();
    test_store();
    test_hold();
    test_reset_mid_read();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-port synchronous SRAM between the core's instruction-fetch port and its data load/store port. Arbitrates same-cycle requests with data priority and an inst starvation guard. Returns read data one cycle later with per-requester hold registers, and raises a stall request whenever a requester is refused. Sits between the pipeline core (IF / EX / MEM stages) and the physical memory, in front of the CTRL stall logic.

## Interface
Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- MAX_WAIT, 4, consecutive refused inst cycles before inst is forced to win (≥1)

Ports:
- clk  in  1  clock; all state on rising edge
- rst  in  1  reset, asynchronous, active-low
- inst_req  in  1  fetch read request
- inst_addr  in  ADDR_W  fetch address
- inst_gnt  out  1  fetch accepted this cycle
- inst_rvalid  out  1  fetch data valid (cycle after grant)
- inst_rdata  out  DATA_W  fetch data, held until next inst read returns
- data_req  in  1  load/store request
- data_wen  in  DATA_W/8  byte enables; all-zero = read
- data_addr  in  ADDR_W  data address
- data_wdata  in  DATA_W  store data
- data_gnt  out  1  data access accepted this cycle
- data_rvalid  out  1  load data valid (cycle after read grant)
- data_rdata  out  DATA_W  load data, held until next data read returns
- mem_en  out  1  memory enable
- mem_wen  out  DATA_W/8  memory byte write enables
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid one cycle after mem_en with mem_wen==0
- stallreq  out  1  a request was refused this cycle

## Operation
- Grant is combinational in the request cycle; exactly one of inst_gnt/data_gnt, or neither.
- Priority: data_req wins, unless wait_cnt == MAX_WAIT and inst_req is high; then inst wins.
- Lone requester always wins.
- mem_* mirror the winner: inst → mem_wen=0, mem_addr=inst_addr, mem_wdata=0; data → data_wen/addr/wdata passed through. No winner → mem_en=0, mem_wen=0.
- wait_cnt (width $clog2(MAX_WAIT+1)):
  - +1 (saturating at MAX_WAIT) on cycles with inst_req high and inst_gnt low.
  - Cleared on inst_gnt or inst_req low.
- Owner register tracks the outstanding read: NONE / INST / DATA.
  - Next owner = INST on inst_gnt; DATA on data read grant; NONE otherwise, including data writes.
- Return path:
  - owner INST → inst_rvalid=1 and the inst hold register captures mem_rdata.
  - owner DATA → data_rvalid=1 and the data hold register captures mem_rdata.
  - *_rdata outputs come from the hold registers, so data is stable across core stalls.
- stallreq = (inst_req & ~inst_gnt) | (data_req & ~data_gnt).
- Requests may change freely while refused; the arbiter keeps no request buffering.

## Timing
- Reset (rst low, async):
  - owner=NONE, wait_cnt=0, hold registers=0.
  - inst_rvalid=0, data_rvalid=0, inst_rdata=0, data_rdata=0.
  - Grants, stallreq and mem_* are 0 while rst is low, regardless of requests.
- Read latency is 1: grant in cycle N, *_rvalid and data in cycle N+1.
- Back-to-back reads are fully pipelined: grant in N+1 coexists with the return from N.
- Write latency is 0: the write is committed in the grant cycle, with no rvalid.
- Reset asserted between grant and return: the return is dropped and rvalid stays 0 after release.
- Simultaneous requests with wait_cnt==MAX_WAIT−1: data wins, wait_cnt→MAX_WAIT, and inst wins the next contended cycle.

## Structure
- Shared package (alongside lib/defines.vh):
  - owner encoding constants OWN_NONE=2'd0, OWN_INST=2'd1, OWN_DATA=2'd2.
  - default ADDR_W/DATA_W macros.
- Sub-module rdata_hold, instantiated twice (inst, data): DATA_W register with async active-low clear and capture enable; outputs rvalid (registered capture) and held data.

## Test plan
- Reset: drive both requests high with rst low → all outputs 0. After release, inst_req alone at addr 0xBFC00000 with mem returning 0x3C1D8000 → inst_gnt in N, inst_rvalid=1 and inst_rdata=0x3C1D8000 in N+1.
- Contention: inst_req and data_req (read 0x1000) high for 6 cycles, MAX_WAIT=4 → data granted cycles 0–3, inst granted cycle 4, data cycle 5. stallreq=1 on every cycle.
- Store: data_req with wen=4'b0011, addr 0x2000, wdata 0xDEADBEEF → mem_en=1, mem_wen=4'b0011 same cycle; data_rvalid stays 0 next cycle.
- Hold: data read returns 0x12345678, then 5 cycles of inst-only traffic → data_rdata stays 0x12345678 and data_rvalid pulses once.
- Reset mid-read: inst granted in N, rst low during N+1 → inst_rvalid=0, inst_rdata=0. After release, wait_cnt=0: simultaneous requests give data the grant.
